// File: rtl/reg_file_pkg.sv
// Shared constants and FSM encoding for the 32 x 32-bit register file
// (write bank, read multiplexer and their benches).
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_clear_seq.sv
// IDLE/CLEAR sequencer: walks a clear index over every register, one per cycle,
// then pulses clear_done on the return to IDLE.
module reg_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W_P   = ADDR_W,
  parameter int NUM_REGS_P = NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_req,
  output logic                clear_en,
  output logic [ADDR_W_P-1:0] clear_idx,
  output logic                clear_busy,
  output logic                clear_done,
  output clr_state_e          state_o
);

  clr_state_e          state_d, state_q;
  logic [ADDR_W_P-1:0] idx_d, idx_q;
  logic                done_d, done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + ADDR_W_P'(1);
        // The edge that zeroes the last register also ends the sequence.
        if (idx_q == ADDR_W_P'(NUM_REGS_P - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign clear_en   = (state_q == ST_CLEAR);
  assign clear_idx  = idx_q;
  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = done_q;
  assign state_o    = state_q;

endmodule

// File: rtl/reg_file_write_bank.sv
// Storage and write side of the register file: valid/ready write port, sequenced
// clear, saturating write counter. Optional macro: R0_HARDWIRED_ZERO_EN.
module reg_file_write_bank
  import reg_file_pkg::*;
#(
  parameter int DATA_W_P   = DATA_W,
  parameter int ADDR_W_P   = ADDR_W,
  parameter int NUM_REGS_P = NUM_REGS,
  parameter int CNT_W_P    = CNT_W
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           WrValid,
  output logic                           WrReady,
  input  logic [ADDR_W_P-1:0]            WrAdd,
  input  logic [DATA_W_P-1:0]            WrData,
  input  logic                           ClearReq,
  output logic                           ClearBusy,
  output logic                           ClearDone,
  output logic [NUM_REGS_P*DATA_W_P-1:0] RegsFlat,
  output logic [CNT_W_P-1:0]             WrCount
);

`ifdef R0_HARDWIRED_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // Handshake: a write transfers on a rising edge where WrValid and WrReady are
  // both high; the producer holds WrAdd/WrData/WrValid stable until that edge.
  logic                clear_en;
  logic [ADDR_W_P-1:0] clear_idx;
  clr_state_e          seq_state;
  logic                xfer;

  reg_clear_seq #(
    .ADDR_W_P   (ADDR_W_P),
    .NUM_REGS_P (NUM_REGS_P)
  ) u_clear_seq (
    .clk        (Clk),
    .rst        (Rst),
    .clear_req  (ClearReq),
    .clear_en   (clear_en),
    .clear_idx  (clear_idx),
    .clear_busy (ClearBusy),
    .clear_done (ClearDone),
    .state_o    (seq_state)
  );

  // A clear request in IDLE wins over a simultaneous write.
  assign WrReady = !Rst && (seq_state == ST_IDLE) && !ClearReq;
  assign xfer    = WrValid && WrReady;

  for (genvar i = 0; i < NUM_REGS_P; i++) begin : g_reg
    if (R0_ZERO && (i == 0)) begin : g_zero
      assign RegsFlat[i*DATA_W_P +: DATA_W_P] = '0;
    end else begin : g_flop
      logic [DATA_W_P-1:0] reg_d, reg_q;

      always_comb begin
        reg_d = reg_q;
        if (clear_en && (clear_idx == ADDR_W_P'(i))) begin
          reg_d = '0;
        end else if (xfer && (WrAdd == ADDR_W_P'(i))) begin
          reg_d = WrData;
        end
      end

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign RegsFlat[i*DATA_W_P +: DATA_W_P] = reg_q;
    end
  end

  logic [CNT_W_P-1:0] wr_count_d, wr_count_q;

  always_comb begin
    wr_count_d = wr_count_q;
    if (xfer && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + CNT_W_P'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign WrCount = wr_count_q;

endmodule

// File: tb/tb_reg_file_write_bank.sv
// Self-checking bench for reg_file_write_bank: scoreboard of accepted writes
// plus a register model checked against RegsFlat.
module tb_reg_file_write_bank;
  import reg_file_pkg::*;

`ifdef R0_HARDWIRED_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic                       Clk;
  logic                       Rst;
  logic                       WrValid;
  logic                       WrReady;
  logic [ADDR_W-1:0]          WrAdd;
  logic [DATA_W-1:0]          WrData;
  logic                       ClearReq;
  logic                       ClearBusy;
  logic                       ClearDone;
  logic [NUM_REGS*DATA_W-1:0] RegsFlat;
  logic [CNT_W-1:0]           WrCount;

  reg_file_write_bank dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .WrValid   (WrValid),
    .WrReady   (WrReady),
    .WrAdd     (WrAdd),
    .WrData    (WrData),
    .ClearReq  (ClearReq),
    .ClearBusy (ClearBusy),
    .ClearDone (ClearDone),
    .RegsFlat  (RegsFlat),
    .WrCount   (WrCount)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard and model
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] model_regs [NUM_REGS];
  logic [CNT_W-1:0]  model_cnt;

  task automatic model_zero();
    for (int r = 0; r < NUM_REGS; r++) model_regs[r] = '0;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Rst = 1'b1; WrValid = 1'b0; ClearReq = 1'b0; WrAdd = '0; WrData = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    model_zero();
    model_cnt = '0;
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic push_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] e;
    e = (R0_ZERO && a == '0) ? '0 : d;
    exp_q.push_back(e);
    addr_q.push_back(a);
    model_regs[a] = e;
    if (model_cnt != '1) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic pop_check(input string name);
    logic [DATA_W-1:0] e;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] got;
    e = exp_q.pop_front();
    a = addr_q.pop_front();
    got = RegsFlat[int'(a)*DATA_W +: DATA_W];
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s reg[%0d]: got %h expected %h", name, a, got, e);
    end
  endtask

  task automatic check_all(input string name);
    for (int r = 0; r < NUM_REGS; r++) begin
      n_checks++;
      if (RegsFlat[r*DATA_W +: DATA_W] !== model_regs[r]) begin
        n_fail++;
        $display("FAIL %s reg[%0d]: got %h expected %h", name, r,
                 RegsFlat[r*DATA_W +: DATA_W], model_regs[r]);
      end
    end
  endtask

  task automatic check_count(input string name);
    n_checks++;
    if (WrCount !== model_cnt) begin
      n_fail++;
      $display("FAIL %s WrCount: got %h expected %h", name, WrCount, model_cnt);
    end
  endtask

  // driver: one write, handshake bounded to 100 cycles
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input string name);
    bit ok;
    ok = 1'b0;
    @(negedge Clk);
    WrValid = 1'b1; WrAdd = a; WrData = d;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (WrReady) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s handshake: WrReady stayed 0 for 100 cycles, expected 1", name);
      WrValid = 1'b0;
      return;
    end
    @(posedge Clk);
    push_write(a, d);
    @(negedge Clk);
    WrValid = 1'b0;
    pop_check(name);
    check_count(name);
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b1; WrValid = 1'b1; ClearReq = 1'b0; WrAdd = 5'd3; WrData = 32'h1234;
    #1;
    n_checks++;
    if (WrReady !== 1'b0) begin n_fail++; $display("FAIL reset WrReady: got %b expected 0", WrReady); end
    @(negedge Clk);
    n_checks++;
    if (ClearBusy !== 1'b0 || ClearDone !== 1'b0) begin
      n_fail++;
      $display("FAIL reset clear flags: got busy=%b done=%b expected 0/0", ClearBusy, ClearDone);
    end
    model_zero();
    model_cnt = '0;
    check_count("reset");
    check_all("reset");
    apply_reset();
  endtask

  task automatic test_reset_then_write();
    apply_reset();
    do_write(5'd5, 32'hDEADBEEF, "write5");
    n_checks++;
    if (RegsFlat[191:160] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write5 slice: got %h expected deadbeef", RegsFlat[191:160]);
    end
    check_all("write5_all");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      @(negedge Clk);
      if (exp_q.size() != 0) pop_check("b2b");
      WrValid = 1'b1; WrAdd = ADDR_W'(i); WrData = DATA_W'(i + 100);
      #1;
      n_checks++;
      if (WrReady !== 1'b1) begin n_fail++; $display("FAIL b2b WrReady[%0d]: got %b expected 1", i, WrReady); end
      @(posedge Clk);
      push_write(ADDR_W'(i), DATA_W'(i + 100));
    end
    @(negedge Clk);
    WrValid = 1'b0;
    pop_check("b2b");
    check_all("b2b_all");
    n_checks++;
    if (WrCount !== 16'd32) begin n_fail++; $display("FAIL b2b WrCount: got %0d expected 32", WrCount); end
  endtask

  task automatic test_clear_collision();
    int  busy_cycles;
    bit  done_seen;
    logic [CNT_W-1:0] cnt_before;
    busy_cycles = 0;
    done_seen   = 1'b0;
    cnt_before  = model_cnt;
    @(negedge Clk);
    ClearReq = 1'b1; WrValid = 1'b1; WrAdd = 5'd7; WrData = 32'hA5A5_0F0F;
    #1;
    n_checks++;
    if (WrReady !== 1'b0) begin n_fail++; $display("FAIL collide WrReady: got %b expected 0", WrReady); end
    @(negedge Clk);
    ClearReq = 1'b0;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      #1;
      if (ClearBusy) begin
        busy_cycles++;
        n_checks++;
        if (WrReady !== 1'b0) begin n_fail++; $display("FAIL collide busy WrReady: got %b expected 0", WrReady); end
      end
      if (ClearDone) begin
        done_seen = 1'b1;
      end else begin
        @(negedge Clk);
      end
    end
    n_checks++;
    if (!done_seen) begin n_fail++; $display("FAIL collide ClearDone: got no pulse expected one"); end
    n_checks++;
    if (busy_cycles != 32) begin n_fail++; $display("FAIL collide busy length: got %0d expected 32", busy_cycles); end
    model_zero();
    check_all("collide_cleared");
    n_checks++;
    if (WrReady !== 1'b1) begin n_fail++; $display("FAIL collide done WrReady: got %b expected 1", WrReady); end
    @(posedge Clk);
    push_write(5'd7, 32'hA5A5_0F0F);
    @(negedge Clk);
    WrValid = 1'b0;
    n_checks++;
    if (ClearDone !== 1'b0) begin n_fail++; $display("FAIL collide done width: got %b expected 0", ClearDone); end
    pop_check("collide_held");
    check_all("collide_all");
    n_checks++;
    if (WrCount !== cnt_before + 16'd1) begin
      n_fail++;
      $display("FAIL collide WrCount: got %0d expected %0d", WrCount, cnt_before + 16'd1);
    end
  endtask

  task automatic test_reset_mid_clear();
    bit bad;
    bad = 1'b0;
    @(negedge Clk);
    ClearReq = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    ClearReq = 1'b0;
    repeat (9) @(negedge Clk);
    n_checks++;
    if (ClearBusy !== 1'b1) begin n_fail++; $display("FAIL midclr busy: got %b expected 1", ClearBusy); end
    Rst = 1'b1;
    #1;
    n_checks++;
    if (ClearBusy !== 1'b0 || ClearDone !== 1'b0 || WrReady !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr outputs: got busy=%b done=%b ready=%b expected 0/0/0",
               ClearBusy, ClearDone, WrReady);
    end
    model_zero();
    model_cnt = '0;
    check_all("midclr_regs");
    check_count("midclr");
    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (ClearDone !== 1'b0 || ClearBusy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL midclr after: got ClearDone/ClearBusy activity expected none"); end
  endtask

  task automatic test_r0();
    apply_reset();
    do_write(5'd0, 32'h1, "r0");
    check_all("r0_all");
  endtask

  task automatic test_saturation();
    apply_reset();
    @(negedge Clk);
    force dut.wr_count_q = 16'hFFFE;
    #1;
    release dut.wr_count_q;
    model_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      do_write(ADDR_W'($urandom_range(1, NUM_REGS - 1)), DATA_W'($urandom), "sat");
    end
    n_checks++;
    if (WrCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat final: got %h expected ffff", WrCount); end
  endtask

  initial begin
    Rst = 1'b1; WrValid = 1'b0; ClearReq = 1'b0; WrAdd = '0; WrData = '0;
    model_zero();
    model_cnt = '0;
    test_reset();
    test_reset_then_write();
    test_back_to_back();
    test_clear_collision();
    test_reset_mid_clear();
    test_r0();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
